// File: rtl/meteor_scheduler.sv
// Meteor game pacing controller: turns frame markers into meteor step/spawn
// pulses, tracks difficulty level and handles start/pause/game-over flow.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | after reset, waiting for the first start
// RUN     | game active, frames advance meteors and timers
// PAUSED  | game frozen, only pause resumes
// OVER    | collision seen, counters frozen until restart
module meteor_scheduler #(
    parameter int FRAMES_PER_LEVEL = 600,
    parameter int MAX_LEVEL        = 8,
    parameter int SPAWN_BASE       = 40,
    parameter int SPAWN_MIN        = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame,
    input  logic        start,
    input  logic        pause,
    input  logic        collision,
    output logic [15:0] level,
    output logic        met_step,
    output logic        spawn,
    output logic [1:0]  spawn_lane,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_OVER   = 2'b11
    } state_t;

    localparam logic [15:0] FPL_LAST = 16'(FRAMES_PER_LEVEL - 1);
    localparam logic [15:0] LVL_MAX  = 16'(MAX_LEVEL);
    localparam logic [15:0] BASE16   = 16'(SPAWN_BASE);
    localparam logic [15:0] MIN16    = 16'(SPAWN_MIN);
    localparam logic [18:0] BASE19   = 19'(SPAWN_BASE);
    localparam logic [18:0] MIN19    = 19'(SPAWN_MIN);

    state_t      state_q, state_d;
    logic [15:0] level_q, level_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] spawn_timer_q, spawn_timer_d;
    logic        met_step_q, met_step_d;
    logic        spawn_q, spawn_d;
    logic [1:0]  spawn_lane_q, spawn_lane_d;
    logic [3:0]  lfsr_q, lfsr_d;
    logic        frame_d_q;

    logic        frame_rise;
    logic [15:0] fc_nxt;
    logic [15:0] lvl_nxt;
    logic [18:0] lvl_x4;
    logic [15:0] reload;

    always_comb begin
        frame_rise = frame & ~frame_d_q;
        lfsr_d     = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

        // Frame/level advance, used only when a frame is actually counted
        fc_nxt  = frame_cnt_q + 16'd1;
        lvl_nxt = level_q;
        if (frame_cnt_q == FPL_LAST) begin
            fc_nxt = 16'd0;
            if (level_q < LVL_MAX) begin
                lvl_nxt = level_q + 16'd1;
            end
        end

        // Reload uses the post-increment level; wide math keeps BASE-4*level from wrapping
        lvl_x4 = {1'b0, lvl_nxt, 2'b00};
        if (lvl_x4 + MIN19 >= BASE19) begin
            reload = MIN16;
        end else begin
            reload = 16'(BASE19 - lvl_x4);
        end
    end

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        frame_cnt_d   = frame_cnt_q;
        spawn_timer_d = spawn_timer_q;
        met_step_d    = 1'b0;
        spawn_d       = 1'b0;
        spawn_lane_d  = spawn_lane_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d       = ST_RUN;
                    level_d       = 16'd1;
                    frame_cnt_d   = 16'd0;
                    spawn_timer_d = BASE16;
                end
            end
            ST_RUN: begin
                if (collision) begin
                    state_d = ST_OVER;
                end else begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end
                    if (frame_rise) begin
                        met_step_d  = 1'b1;
                        frame_cnt_d = fc_nxt;
                        level_d     = lvl_nxt;
                        if (spawn_timer_q == 16'd1) begin
                            spawn_d       = 1'b1;
                            spawn_timer_d = reload;
                            // Lane matches the LFSR value visible while spawn is high
                            spawn_lane_d  = lfsr_d[1:0];
                        end else begin
                            spawn_timer_d = spawn_timer_q - 16'd1;
                        end
                    end
                end
            end
            ST_PAUSED: begin
                if (pause) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            level_q       <= 16'd0;
            frame_cnt_q   <= 16'd0;
            spawn_timer_q <= BASE16;
            met_step_q    <= 1'b0;
            spawn_q       <= 1'b0;
            spawn_lane_q  <= 2'b00;
            lfsr_q        <= 4'b0001;
            frame_d_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            frame_cnt_q   <= frame_cnt_d;
            spawn_timer_q <= spawn_timer_d;
            met_step_q    <= met_step_d;
            spawn_q       <= spawn_d;
            spawn_lane_q  <= spawn_lane_d;
            lfsr_q        <= lfsr_d;
            frame_d_q     <= frame;
        end
    end

    assign level      = level_q;
    assign met_step   = met_step_q;
    assign spawn      = spawn_q;
    assign spawn_lane = spawn_lane_q;
    assign state      = state_q;

endmodule

// File: tb/tb_meteor_scheduler.sv
// Scoreboard bench for meteor_scheduler: the driver queues expected step/spawn
// responses per frame, a negedge monitor pops and compares on each met_step.
module tb_meteor_scheduler;

    localparam int FPL  = 4;
    localparam int MAXL = 3;
    localparam int BASE = 12;
    localparam int MINS = 4;

    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSED = 2'b10, S_OVER = 2'b11;

    logic        clk, resetn, frame, start, pause, collision;
    logic [15:0] level;
    logic        met_step, spawn;
    logic [1:0]  spawn_lane, state;

    meteor_scheduler #(
        .FRAMES_PER_LEVEL(FPL), .MAX_LEVEL(MAXL), .SPAWN_BASE(BASE), .SPAWN_MIN(MINS)
    ) dut (
        .clk(clk), .resetn(resetn), .frame(frame), .start(start), .pause(pause),
        .collision(collision), .level(level), .met_step(met_step), .spawn(spawn),
        .spawn_lane(spawn_lane), .state(state)
    );

    typedef struct {
        int          cyc;
        logic        sp;
        logic [15:0] lvl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_spawn  = 0;
    int   cyc      = 0;
    logic [3:0] tl;

    logic [1:0]  m_state;
    int          m_level, m_fc, m_timer;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!resetn) tl <= 4'b0001;
        else         tl <= {tl[2:0], tl[3] ^ tl[2]};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: actual %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: every met_step must match the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (met_step) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_met_step", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("step_latency_cycle", cyc, e.cyc);
                    chk("spawn_with_step", {31'd0, spawn}, {31'd0, e.sp});
                    chk("level_at_step", {16'd0, level}, {16'd0, e.lvl});
                    if (e.sp) chk("spawn_lane", {30'd0, spawn_lane}, {30'd0, tl[1:0]});
                    if (spawn) n_spawn++;
                end
            end else if (spawn) begin
                chk("spawn_without_step", 1, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_level = 0; m_fc = 0; m_timer = BASE;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_state == S_IDLE || m_state == S_OVER) begin
            m_state = S_RUN; m_level = 1; m_fc = 0; m_timer = BASE;
        end
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        tick();
        pause = 1'b0;
        if (m_state == S_RUN)         m_state = S_PAUSED;
        else if (m_state == S_PAUSED) m_state = S_RUN;
    endtask

    // Two-cycle-high frame; expectation queued only when the model is running
    task automatic do_frame();
        exp_t e;
        int   rl;
        frame = 1'b1;
        if (m_state == S_RUN) begin
            if (m_fc == FPL - 1) begin
                m_fc = 0;
                if (m_level < MAXL) m_level++;
            end else begin
                m_fc++;
            end
            e.sp = 1'b0;
            if (m_timer == 1) begin
                e.sp = 1'b1;
                rl = BASE - 4 * m_level;
                m_timer = (rl > MINS) ? rl : MINS;
            end else begin
                m_timer--;
            end
            e.cyc = cyc + 1;
            e.lvl = 16'(m_level);
            exp_q.push_back(e);
        end
        tick();
        tick();
        frame = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_state(input string nm);
        chk({nm, "_state"}, {30'd0, state}, {30'd0, m_state});
        chk({nm, "_level"}, {16'd0, level}, 32'(m_level));
    endtask

    initial begin
        int sp0;
        resetn = 1'b0; frame = 1'b0; start = 1'b0; pause = 1'b0; collision = 1'b0;
        model_reset();

        // Reset held while frame toggles
        for (int i = 0; i < 3; i++) begin
            frame = ~frame;
            tick();
            chk("rst_state", {30'd0, state}, 0);
            chk("rst_level", {16'd0, level}, 0);
            chk("rst_met_step", {31'd0, met_step}, 0);
            chk("rst_spawn", {31'd0, spawn}, 0);
        end
        frame = 1'b0;
        resetn = 1'b1;
        tick();
        chk("rst_lane", {30'd0, spawn_lane}, 0);
        chk("rst_timer", {16'd0, dut.spawn_timer_q}, BASE);

        // Pause and frames in IDLE have no effect
        pulse_pause();
        chk_state("idle_pause");
        do_frame();
        chk_state("idle_frame");

        // Start then 4 frames: level 1 -> 2 on the 4th
        pulse_start();
        chk_state("start1");
        chk("start1_level_const", {16'd0, level}, 1);
        do_frame(); do_frame(); do_frame();
        chk("lvl_before_4th", {16'd0, level}, 1);
        do_frame();
        chk("lvl_after_4th", {16'd0, level}, 2);

        // Start ignored while running
        pulse_start();
        chk_state("run_start_ignored");
        chk("run_start_fc", {16'd0, dut.frame_cnt_q}, 0);

        // Collision coincident with frame rise at level 2
        frame = 1'b1; collision = 1'b1;
        m_state = S_OVER;
        tick();
        collision = 1'b0;
        tick();
        frame = 1'b0;
        tick(); tick();
        chk("coll_state", {30'd0, state}, 3);
        chk("coll_level", {16'd0, level}, 2);
        do_frame();
        chk_state("over_frame");
        pulse_pause();
        chk_state("over_pause");
        pulse_start();
        chk("restart_state", {30'd0, state}, 1);
        chk("restart_level", {16'd0, level}, 1);

        // 20 frames: level saturates at 3, spawns on frames 12/16/20
        sp0 = n_spawn;
        for (int f = 1; f <= 20; f++) begin
            do_frame();
            if (f == 8)  chk("lvl_after_8", {16'd0, level}, 3);
            if (f == 11) chk("no_spawn_before_12", 32'(n_spawn - sp0), 0);
        end
        chk("lvl_after_20", {16'd0, level}, 3);
        chk("spawn_count_20", 32'(n_spawn - sp0), 3);
        chk("timer_after_20", {16'd0, dut.spawn_timer_q}, 4);

        // Pause: frames, collision and start ignored; counters frozen
        pulse_pause();
        chk("pause_state", {30'd0, state}, 2);
        do_frame(); do_frame(); do_frame();
        collision = 1'b1;
        tick();
        collision = 1'b0;
        pulse_start();
        chk_state("paused_hold");
        chk("paused_fc", {16'd0, dut.frame_cnt_q}, 32'(m_fc));
        chk("paused_timer", {16'd0, dut.spawn_timer_q}, 32'(m_timer));
        pulse_pause();
        chk("resume_state", {30'd0, state}, 1);
        do_frame();
        chk_state("resume_frame");

        // Pause and collision together -> OVER
        pause = 1'b1; collision = 1'b1;
        m_state = S_OVER;
        tick();
        pause = 1'b0; collision = 1'b0;
        chk_state("pause_coll");

        // Reset mid-run at level 3
        pulse_start();
        for (int f = 0; f < 8; f++) do_frame();
        chk("pre_reset_level", {16'd0, level}, 3);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        model_reset();
        chk("midrst_state", {30'd0, state}, 0);
        chk("midrst_level", {16'd0, level}, 0);
        chk("midrst_timer", {16'd0, dut.spawn_timer_q}, 12);
        do_frame();
        chk_state("post_rst_idle");
        pulse_start();
        chk_state("post_rst_start");
        do_frame();

        tick(); tick(); tick();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
